// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register. It holds one decoded instruction for the execute stage.
// While EX stalls, the held register operands are refreshed from write-back so they do not go stale.
module id_ex_stage_reg #(
  parameter int WORD_W  = 32,
  parameter int OP_W    = 8,
  parameter int SEL_W   = 8,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SEL_W-1:0]   id_alusel,
  input  logic [OP_W-1:0]    id_aluop,
  input  logic [WORD_W-1:0]  id_srcLeft,
  input  logic [WORD_W-1:0]  id_srcRight,
  input  logic               id_srcLeftRe,
  input  logic               id_srcRightRe,
  input  logic [RADDR_W-1:0] id_srcLeftAddr,
  input  logic [RADDR_W-1:0] id_srcRightAddr,
  input  logic               id_wreg,
  input  logic [RADDR_W-1:0] id_waddr,
  input  logic               stall_id,
  input  logic               stall_ex,
  input  logic               flush,
  input  logic               wb_we,
  input  logic [RADDR_W-1:0] wb_waddr,
  input  logic [WORD_W-1:0]  wb_wdata,
  output logic [SEL_W-1:0]   ex_alusel,
  output logic [OP_W-1:0]    ex_aluop,
  output logic [WORD_W-1:0]  ex_srcLeft,
  output logic [WORD_W-1:0]  ex_srcRight,
  output logic               ex_wreg,
  output logic [RADDR_W-1:0] ex_waddr,
  output logic               ex_valid
);

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_BUBBLE = 2'd2,
    ACT_FLUSH  = 2'd3
  } act_e;

  act_e act;

  logic [SEL_W-1:0]   alusel_q, alusel_d;
  logic [OP_W-1:0]    aluop_q, aluop_d;
  logic [WORD_W-1:0]  src_l_q, src_l_d;
  logic [WORD_W-1:0]  src_r_q, src_r_d;
  logic               l_re_q, l_re_d;
  logic               r_re_q, r_re_d;
  logic [RADDR_W-1:0] l_addr_q, l_addr_d;
  logic [RADDR_W-1:0] r_addr_q, r_addr_d;
  logic               wreg_q, wreg_d;
  logic [RADDR_W-1:0] waddr_q, waddr_d;
  logic               valid_q, valid_d;

  logic wb_hit;
  logic refresh_l;
  logic refresh_r;

  // Rules are checked in priority order: flush beats every stall.
  always_comb begin
    if (flush) begin
      act = ACT_FLUSH;
    end else if (stall_id && !stall_ex) begin
      act = ACT_BUBBLE;
    end else if (stall_ex) begin
      act = ACT_HOLD;
    end else begin
      act = ACT_LOAD;
    end
  end

  // Register 0 is hard-wired to zero, so a write-back to it never refreshes an operand.
  assign wb_hit    = valid_q && wb_we && (wb_waddr != '0);
  assign refresh_l = wb_hit && l_re_q && (wb_waddr == l_addr_q);
  assign refresh_r = wb_hit && r_re_q && (wb_waddr == r_addr_q);

  always_comb begin
    alusel_d = alusel_q;
    aluop_d  = aluop_q;
    src_l_d  = src_l_q;
    src_r_d  = src_r_q;
    l_re_d   = l_re_q;
    r_re_d   = r_re_q;
    l_addr_d = l_addr_q;
    r_addr_d = r_addr_q;
    wreg_d   = wreg_q;
    waddr_d  = waddr_q;
    valid_d  = valid_q;
    case (act)
      ACT_FLUSH, ACT_BUBBLE: begin
        alusel_d = '0;
        aluop_d  = '0;
        src_l_d  = '0;
        src_r_d  = '0;
        l_re_d   = 1'b0;
        r_re_d   = 1'b0;
        l_addr_d = '0;
        r_addr_d = '0;
        wreg_d   = 1'b0;
        waddr_d  = '0;
        valid_d  = 1'b0;
      end
      ACT_HOLD: begin
        if (refresh_l) src_l_d = wb_wdata;
        if (refresh_r) src_r_d = wb_wdata;
      end
      default: begin
        alusel_d = id_alusel;
        aluop_d  = id_aluop;
        src_l_d  = id_srcLeft;
        src_r_d  = id_srcRight;
        l_re_d   = id_srcLeftRe;
        r_re_d   = id_srcRightRe;
        l_addr_d = id_srcLeftAddr;
        r_addr_d = id_srcRightAddr;
        wreg_d   = id_wreg;
        waddr_d  = id_waddr;
        valid_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alusel_q <= '0;
      aluop_q  <= '0;
      src_l_q  <= '0;
      src_r_q  <= '0;
      l_re_q   <= 1'b0;
      r_re_q   <= 1'b0;
      l_addr_q <= '0;
      r_addr_q <= '0;
      wreg_q   <= 1'b0;
      waddr_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      alusel_q <= alusel_d;
      aluop_q  <= aluop_d;
      src_l_q  <= src_l_d;
      src_r_q  <= src_r_d;
      l_re_q   <= l_re_d;
      r_re_q   <= r_re_d;
      l_addr_q <= l_addr_d;
      r_addr_q <= r_addr_d;
      wreg_q   <= wreg_d;
      waddr_q  <= waddr_d;
      valid_q  <= valid_d;
    end
  end

  assign ex_alusel   = alusel_q;
  assign ex_aluop    = aluop_q;
  assign ex_srcLeft  = src_l_q;
  assign ex_srcRight = src_r_q;
  assign ex_wreg     = wreg_q;
  assign ex_waddr    = waddr_q;
  assign ex_valid    = valid_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed scenarios plus a randomized run.
// A behavioural model predicts the EX-side fields after each edge.
module tb_id_ex_stage_reg;
  localparam int WORD_W  = 32;
  localparam int OP_W    = 8;
  localparam int SEL_W   = 8;
  localparam int RADDR_W = 5;
  localparam int PKT_W   = SEL_W + OP_W + 2*WORD_W + 1 + RADDR_W + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic [SEL_W-1:0]   id_alusel;
  logic [OP_W-1:0]    id_aluop;
  logic [WORD_W-1:0]  id_srcLeft, id_srcRight;
  logic               id_srcLeftRe, id_srcRightRe;
  logic [RADDR_W-1:0] id_srcLeftAddr, id_srcRightAddr;
  logic               id_wreg;
  logic [RADDR_W-1:0] id_waddr;
  logic               stall_id, stall_ex, flush;
  logic               wb_we;
  logic [RADDR_W-1:0] wb_waddr;
  logic [WORD_W-1:0]  wb_wdata;
  logic [SEL_W-1:0]   ex_alusel;
  logic [OP_W-1:0]    ex_aluop;
  logic [WORD_W-1:0]  ex_srcLeft, ex_srcRight;
  logic               ex_wreg;
  logic [RADDR_W-1:0] ex_waddr;
  logic               ex_valid;

  int total = 0;
  int bad   = 0;

  logic [PKT_W-1:0] exp_q[$];

  // Model of the stored instruction, including the hidden Re flags and source addresses.
  logic [SEL_W-1:0]   m_sel;
  logic [OP_W-1:0]    m_op;
  logic [WORD_W-1:0]  m_l, m_r;
  logic               m_lre, m_rre;
  logic [RADDR_W-1:0] m_la, m_ra;
  logic               m_wreg;
  logic [RADDR_W-1:0] m_wa;
  logic               m_valid;

  id_ex_stage_reg #(
    .WORD_W(WORD_W), .OP_W(OP_W), .SEL_W(SEL_W), .RADDR_W(RADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_alusel(id_alusel), .id_aluop(id_aluop),
    .id_srcLeft(id_srcLeft), .id_srcRight(id_srcRight),
    .id_srcLeftRe(id_srcLeftRe), .id_srcRightRe(id_srcRightRe),
    .id_srcLeftAddr(id_srcLeftAddr), .id_srcRightAddr(id_srcRightAddr),
    .id_wreg(id_wreg), .id_waddr(id_waddr),
    .stall_id(stall_id), .stall_ex(stall_ex), .flush(flush),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .ex_alusel(ex_alusel), .ex_aluop(ex_aluop),
    .ex_srcLeft(ex_srcLeft), .ex_srcRight(ex_srcRight),
    .ex_wreg(ex_wreg), .ex_waddr(ex_waddr), .ex_valid(ex_valid)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_sel = '0; m_op = '0; m_l = '0; m_r = '0;
    m_lre = 1'b0; m_rre = 1'b0; m_la = '0; m_ra = '0;
    m_wreg = 1'b0; m_wa = '0; m_valid = 1'b0;
  endtask

  // Apply one edge of the rules to the model and queue the fields EX should see afterwards.
  task automatic model_step();
    if (flush || (stall_id && !stall_ex)) begin
      model_clear();
    end else if (stall_ex) begin
      if (m_valid && wb_we && wb_waddr != 0) begin
        if (m_lre && wb_waddr == m_la) m_l = wb_wdata;
        if (m_rre && wb_waddr == m_ra) m_r = wb_wdata;
      end
    end else begin
      m_sel = id_alusel; m_op = id_aluop;
      m_l = id_srcLeft; m_r = id_srcRight;
      m_lre = id_srcLeftRe; m_rre = id_srcRightRe;
      m_la = id_srcLeftAddr; m_ra = id_srcRightAddr;
      m_wreg = id_wreg; m_wa = id_waddr; m_valid = 1'b1;
    end
    exp_q.push_back({m_sel, m_op, m_l, m_r, m_wreg, m_wa, m_valid});
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ctl(input logic f, input logic sid, input logic sex);
    flush = f; stall_id = sid; stall_ex = sex;
  endtask

  task automatic set_wb(input logic we, input logic [RADDR_W-1:0] a, input logic [WORD_W-1:0] d);
    wb_we = we; wb_waddr = a; wb_wdata = d;
  endtask

  task automatic set_id(input logic [SEL_W-1:0] sel, input logic [OP_W-1:0] op,
                        input logic [WORD_W-1:0] l, input logic [WORD_W-1:0] r,
                        input logic lre, input logic [RADDR_W-1:0] la,
                        input logic rre, input logic [RADDR_W-1:0] ra,
                        input logic wr, input logic [RADDR_W-1:0] wa);
    id_alusel = sel; id_aluop = op; id_srcLeft = l; id_srcRight = r;
    id_srcLeftRe = lre; id_srcLeftAddr = la; id_srcRightRe = rre; id_srcRightAddr = ra;
    id_wreg = wr; id_waddr = wa;
  endtask

  task automatic rand_id();
    logic [SEL_W-1:0] one = 1;
    set_id(($urandom_range(0, 3) == 0) ? '0 : (one << $urandom_range(0, SEL_W-1)),
           OP_W'($urandom), $urandom, $urandom,
           1'($urandom), RADDR_W'($urandom_range(0, 3)),
           1'($urandom), RADDR_W'($urandom_range(0, 3)),
           1'($urandom), RADDR_W'($urandom));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_alusel"}, WORD_W'(ex_alusel), 0);
    check({tag, "_aluop"}, WORD_W'(ex_aluop), 0);
    check({tag, "_srcl"}, ex_srcLeft, 0);
    check({tag, "_srcr"}, ex_srcRight, 0);
    check({tag, "_wreg"}, WORD_W'(ex_wreg), 0);
    check({tag, "_waddr"}, WORD_W'(ex_waddr), 0);
    check({tag, "_valid"}, WORD_W'(ex_valid), 0);
  endtask

  // ---------------- scoreboard ----------------
  always @(posedge clk) begin
    logic [PKT_W-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_alusel", WORD_W'(ex_alusel), WORD_W'(e[PKT_W-1 -: SEL_W]));
      check("sb_aluop", WORD_W'(ex_aluop), WORD_W'(e[PKT_W-SEL_W-1 -: OP_W]));
      check("sb_srcl", ex_srcLeft, e[2*WORD_W+RADDR_W+1 -: WORD_W]);
      check("sb_srcr", ex_srcRight, e[WORD_W+RADDR_W+1 -: WORD_W]);
      check("sb_wreg", WORD_W'(ex_wreg), WORD_W'(e[RADDR_W+1]));
      check("sb_waddr", WORD_W'(ex_waddr), WORD_W'(e[RADDR_W:1]));
      check("sb_valid", WORD_W'(ex_valid), WORD_W'(e[0]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    set_ctl(0, 0, 0);
    set_wb(0, 0, 0);
    set_id(8'h10, 8'h7F, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1, 5'd4, 1, 5'd6, 1, 5'd9);
    model_clear();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Plain load
    set_id(8'h04, 8'h25, 32'hF0F0_0000, 32'h0000_FFFF, 1, 5'd3, 0, 5'd5, 1, 5'd8);
    cycle();
    check("load_aluop", WORD_W'(ex_aluop), 32'h25);
    check("load_srcl", ex_srcLeft, 32'hF0F0_0000);
    check("load_srcr", ex_srcRight, 32'h0000_FFFF);
    check("load_waddr", WORD_W'(ex_waddr), 32'd8);
    check("load_valid", WORD_W'(ex_valid), 32'd1);

    // Refresh while held. Write-backs to r0 and to an immediate operand's address must be ignored.
    set_ctl(0, 0, 1);
    rand_id();
    set_wb(1, 5'd3, 32'h1234_5678);
    cycle();
    check("refresh_srcl", ex_srcLeft, 32'h1234_5678);
    check("refresh_srcr", ex_srcRight, 32'h0000_FFFF);
    set_wb(1, 5'd0, 32'hDEAD_0000);
    cycle();
    check("refresh_r0", ex_srcLeft, 32'h1234_5678);
    set_wb(1, 5'd5, 32'hBAD0_BAD0);
    cycle();
    check("refresh_imm", ex_srcRight, 32'h0000_FFFF);
    check("hold_aluop", WORD_W'(ex_aluop), 32'h25);

    // Bubble, then hold the bubble with new inputs on ID.
    set_wb(0, 0, 0);
    set_ctl(0, 1, 0);
    cycle();
    check_all_zero("bubble");
    set_ctl(0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      rand_id();
      cycle();
      check("bubble_hold_valid", WORD_W'(ex_valid), 0);
      check("bubble_hold_aluop", WORD_W'(ex_aluop), 0);
    end

    // Flush wins over a stall.
    set_ctl(0, 0, 0);
    set_id(8'h01, 8'h11, 32'h1, 32'h2, 1, 5'd1, 1, 5'd2, 1, 5'd3);
    cycle();
    set_ctl(1, 0, 1);
    cycle();
    check_all_zero("flush");

    // Both operands read the same register, so one write-back refreshes both.
    set_ctl(0, 0, 0);
    set_id(8'h02, 8'h33, 32'h1, 32'h2, 1, 5'd9, 1, 5'd9, 1, 5'd9);
    cycle();
    set_ctl(0, 0, 1);
    set_wb(1, 5'd9, 32'hA5A5_A5A5);
    cycle();
    check("dual_srcl", ex_srcLeft, 32'hA5A5_A5A5);
    check("dual_srcr", ex_srcRight, 32'hA5A5_A5A5);

    // An asynchronous reset during a hold drops the held instruction at once.
    set_wb(0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      rand_id();
      set_ctl($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
      set_wb(1'($urandom), RADDR_W'($urandom_range(0, 3)), $urandom);
      cycle();
    end

    set_ctl(0, 0, 1);
    @(negedge clk);
    check("queue_drained", WORD_W'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
